// File: rtl/switch_input_buffer_pkg.sv
// Shared chiplet types used by the switch datapath.
// DEPTH and other per-instance sizing stay local to each block.
package switch_input_buffer_pkg;

    localparam int unsigned FlitWidth = 32;

    typedef logic [FlitWidth-1:0] flit_t;

endpackage

// File: rtl/switch_fifo.sv
// Circular flit store with wrapping read/write pointers and an occupancy count.
// A push at full is accepted only when a pop frees the head slot in the same cycle.
module switch_fifo
    import switch_input_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   push,
    input  logic                   pop,
    input  flit_t                  wdata,
    output flit_t                  rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;
    flit_t           mem_q [DEPTH];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == (PtrW + 1)'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; empty slots are never observed.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/switch_input_buffer.sv
// Per-input switch buffer: queues upstream flits, bids for the arbiter while
// non-empty, returns one credit per pop and flags flits dropped at full.
module switch_input_buffer
    import switch_input_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_valid,
    input  flit_t                  in_flit,
    input  logic                   grant,
    output logic                   bid,
    output flit_t                  rdata,
    output logic                   credit_ret,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("switch_input_buffer: DEPTH must be a power of two >= 2");
    end

    logic full, empty, pop;
    logic credit_ret_q, credit_ret_d;
    logic overflow_q, overflow_d;

    switch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_flit),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pop          = grant & ~empty;
        credit_ret_d = pop;
        // A push at full survives only if the head leaves in the same cycle.
        overflow_d   = overflow_q | (in_valid & full & ~pop);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            credit_ret_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            credit_ret_q <= credit_ret_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bid        = ~empty;
    assign credit_ret = credit_ret_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/switch_input_buffer.md
SWITCH_INPUT_BUFFER -- requirements
Module: switch_input_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning flit slots; power of two, >= 2.
REQ-002 SHALL have port CLK  input  1  clock, all state on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream link presents a flit this cycle.
REQ-005 SHALL have port in_flit  input  flit_t  upstream flit.
REQ-006 SHALL have port grant  input  1  arbiter valid AND arbiter select equals this port's index, formed by the parent.
REQ-007 SHALL have port bid  output  1  request to the switch arbiter.
REQ-008 SHALL have port rdata  output  flit_t  head flit offered to the arbiter.
REQ-009 SHALL have port credit_ret  output  1  one-cycle pulse returning one credit upstream.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  occupied slots.
REQ-011 SHALL have port overflow  output  1  sticky error, flit dropped at full.

Function
REQ-012 SHALL store flits in FIFO order in a DEPTH-entry circular buffer with read/write pointers wrapping DEPTH-1 -> 0.
REQ-013 SHALL push in_flit on a rising edge when in_valid=1 and the buffer is not full.
REQ-014 SHALL pop the head on a rising edge when grant=1 and count>0; grant with count=0 SHALL be ignored, no state change.
REQ-015 SHALL drive bid = (count != 0) combinationally from registered state; no other input affects bid.
REQ-016 SHALL drive rdata = head entry combinationally; rdata SHALL only change on a pop or on a push into an empty buffer.
REQ-017 SHALL give push-to-bid latency of one cycle: flit pushed at edge N is bid and on rdata after edge N.
REQ-018 SHALL keep bid and rdata stable from the cycle the arbiter samples them until the grant cycle; the arbiter registers the flit one cycle before grant.
REQ-019 SHALL, on simultaneous push and pop with 0<count<DEPTH, leave count unchanged and advance both pointers.
REQ-020 SHALL, on simultaneous push and pop at count=DEPTH, accept the push with no overflow and leave count at DEPTH.
REQ-021 SHALL, on push at count=DEPTH without pop, drop in_flit, leave all state unchanged, and set overflow=1 from the next cycle.
REQ-022 SHALL, on push with count=0 and grant=1, push only; no pop occurs.
REQ-023 SHALL assert credit_ret for exactly one cycle, registered, on the cycle after each pop; back-to-back pops SHALL give back-to-back pulses.
REQ-024 SHALL keep overflow set until reset.
REQ-025 SHALL keep count = pushes minus pops since reset, range 0..DEPTH.

Reset
REQ-026 SHALL on nRST low, asynchronously, set pointers=0, count=0, bid=0, credit_ret=0, overflow=0; storage contents need not reset.
REQ-027 SHALL, for a reset asserted mid-operation, discard all buffered flits with no credit_ret pulses for them; upstream credits are re-initialised by the link reset.
REQ-028 SHALL drive rdata as don't-care while count=0; benches SHALL not check it.

Structure
REQ-029 SHALL take flit_t from the shared chiplet types package; DEPTH stays local.
REQ-030 SHALL place storage and pointers in one sub-module, switch_fifo (push, pop, wdata, rdata, count, full, empty); switch_input_buffer adds bid, credit and overflow logic.
REQ-031 SHALL instantiate once per switch input, with grant wired from the switch_arbiter valid/select pair.

Verification
REQ-032 SHALL cover single flit: push 0xA5A5_0001 at cycle 1 -> bid=1, rdata=0xA5A5_0001 at cycle 2; grant at cycle 4 -> bid=0 at cycle 5, credit_ret=1 in cycle 5 only.
REQ-033 SHALL cover fill and drain, DEPTH=8: push 8 flits 0..7 -> count=8; 8 consecutive grants -> rdata 0..7 in order, 8 consecutive credit_ret pulses, count=0.
REQ-034 SHALL cover overflow: 8 pushes then 9th push 0xDEAD, no grant -> overflow=1 next cycle, count=8, drained sequence excludes 0xDEAD.
REQ-035 SHALL cover full push+pop: count=8, push 0x99 with grant -> overflow=0, count=8, 0x99 emerges eighth after the pop.
REQ-036 SHALL cover spurious grant and wrap: grant with count=0 -> no credit_ret, count stays 0; 20 push/pop pairs -> pointers wrap, order preserved.
REQ-037 SHALL cover reset mid-stream: 5 flits buffered, nRST low one cycle -> bid=0, count=0, overflow=0, no credit_ret, next push accepted normally.
